cgu_seq_adder: RTL and testbench

Multi-cycle two's-complement adder controller that sequences one shared `cgu_2bits` carry-generation slice across a WIDTH-bit operand pair, two bits per clock. It latches the operands and carry-in on a start request and walks the slice from LSB to MSB, propagating the carry between cycles. When the sum, carry-out and signed overflow are ready, it raises a one-cycle done pulse. It sits between a requesting datapath (ALU sequencer or testbench driver) and the existing CGU slice, trading latency for area.

---
 rtl/cgu_seq_adder_pkg.sv | 17 +
 rtl/cgu_seq_adder_if.sv | 30 +++
 rtl/cgu_2bits.sv | 17 +
 rtl/cgu_seq_adder.sv | 136 +++++++++++++
 tb/tb_cgu_seq_adder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cgu_seq_adder_pkg.sv
// rtl/cgu_seq_adder_pkg.sv - shared constants and state encoding for the sequential CGU adder
package cgu_seq_adder_pkg;

  // Controller states; encodings are fixed so that other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits consumed per clock by one pass through the carry-generation slice.
  localparam int SLICE = 2;

  // Operand width used when no override is given.
  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/cgu_seq_adder_if.sv
// rtl/cgu_seq_adder_if.sv - request/result bundle between a requester and the sequential adder
interface cgu_seq_adder_if
  import cgu_seq_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester side: issues operands, observes results.
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  // Adder side: consumes operands, produces results.
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/cgu_2bits.sv
// rtl/cgu_2bits.sv - two-bit carry-generation slice (lookahead over one bit pair)
module cgu_2bits (
  input  logic [1:0] g,
  input  logic [1:0] p,
  input  logic       cin,
  output logic [1:0] carry
);

  // carry[0] is the carry out of bit 0, carry[1] the carry out of bit 1,
  // both computed directly from cin so the pair resolves in one level.
  always_comb begin
    carry    = 2'b00;
    carry[0] = g[0] | (p[0] & cin);
    carry[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  end

endmodule

// File: rtl/cgu_seq_adder.sv
// rtl/cgu_seq_adder.sv - multi-cycle adder walking one cgu_2bits slice LSB to MSB
module cgu_seq_adder
  import cgu_seq_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst,
  cgu_seq_adder_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;

  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_nxt;
  logic             cr;

  logic [1:0]       g;
  logic [1:0]       p;
  logic [1:0]       c;
  logic [1:0]       carry;
  logic [1:0]       slice_sum;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  // The bottom pair of the partial sum is shifted out and never read again.
  wire unused_ps_low = &{1'b0, ps[SLICE-1:0]};

  // Slice inputs always come from the bottom pair of the operand shifters.
  assign g         = a_sh[1:0] & b_sh[1:0];
  assign p         = a_sh[1:0] ^ b_sh[1:0];
  assign c         = {carry[0], cr};
  assign slice_sum = p ^ c;
  assign last      = (k == K_LAST);

  cgu_2bits u_cgu (
    .g     (g),
    .p     (p),
    .cin   (cr),
    .carry (carry)
  );

  // New slice result enters at the top; a single-slice adder has nothing to shift.
  generate
    if (WIDTH == SLICE) begin : g_single
      assign ps_nxt = slice_sum;
    end else begin : g_multi
      assign ps_nxt = {slice_sum, ps[WIDTH-1:SLICE]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and status outputs; DONE accepts a new request like IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE, DONE: begin
        bus.done = (state == DONE);
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, per-slice shifting, carry hand-off and final result latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      ps     <= '0;
      cr     <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      k    <= '0;
      a_sh <= bus.a;
      b_sh <= bus.b;
      ps   <= '0;
      cr   <= bus.cin;
    end else if (state == RUN) begin
      k    <= k + KW'(1);
      a_sh <= a_sh >> SLICE;
      b_sh <= b_sh >> SLICE;
      ps   <= ps_nxt;
      cr   <= carry[1];
      if (last) begin
        sum_r  <= ps_nxt;
        cout_r <= carry[1];
        ovf_r  <= carry[0] ^ carry[1];
      end
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_cgu_seq_adder.sv
// tb/tb_cgu_seq_adder.sv - directed self-checking bench for cgu_seq_adder
module tb_cgu_seq_adder;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  cgu_seq_adder_if #(.WIDTH(16)) bus ();

  cgu_seq_adder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and returns edges from accept to done, and busy cycles seen.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       output int lat, output int bcnt);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = cv;
    step();
    bus.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    bus.cin   = 1'b0;
    step();
    step();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests++; if (bus.sum !== 16'h0) begin fails++; $display("FAIL reset_sum: got %h expected 0000", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bcnt;
    do_op(16'h0001, 16'h0001, 1'b0, lat, bcnt);
    tests++; if (lat !== 8) begin fails++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    tests++; if (bcnt !== 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 8", bcnt); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy_in_done: got %b expected 0", bus.busy); end
    tests++; if (bus.sum !== 16'h0002) begin fails++; $display("FAIL basic_sum: got %h expected 0002", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL basic_cout: got %b expected 0", bus.cout); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b expected 0", bus.ovf); end
    step();
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
    tests++; if (bus.sum !== 16'h0002) begin fails++; $display("FAIL basic_sum_hold: got %h expected 0002", bus.sum); end
  endtask

  task automatic test_ripple();
    int lat, bcnt;
    do_op(16'hFFFF, 16'h0001, 1'b0, lat, bcnt);
    tests++; if (lat !== 8) begin fails++; $display("FAIL ripple_latency: got %0d expected 8", lat); end
    tests++; if (bus.sum !== 16'h0000) begin fails++; $display("FAIL ripple_sum: got %h expected 0000", bus.sum); end
    tests++; if (bus.cout !== 1'b1) begin fails++; $display("FAIL ripple_cout: got %b expected 1", bus.cout); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ripple_ovf: got %b expected 0", bus.ovf); end
    step();
  endtask

  task automatic test_overflow();
    int lat, bcnt;
    do_op(16'h7FFF, 16'h0001, 1'b0, lat, bcnt);
    tests++; if (bus.sum !== 16'h8000) begin fails++; $display("FAIL ovf_pos_sum: got %h expected 8000", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL ovf_pos_cout: got %b expected 0", bus.cout); end
    tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_pos_ovf: got %b expected 1", bus.ovf); end
    step();
    do_op(16'h8000, 16'h8000, 1'b0, lat, bcnt);
    tests++; if (bus.sum !== 16'h0000) begin fails++; $display("FAIL ovf_neg_sum: got %h expected 0000", bus.sum); end
    tests++; if (bus.cout !== 1'b1) begin fails++; $display("FAIL ovf_neg_cout: got %b expected 1", bus.cout); end
    tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_neg_ovf: got %b expected 1", bus.ovf); end
    step();
  endtask

  task automatic test_cin();
    int lat, bcnt;
    do_op(16'h1234, 16'h4321, 1'b1, lat, bcnt);
    tests++; if (bus.sum !== 16'h5556) begin fails++; $display("FAIL cin_sum: got %h expected 5556", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL cin_cout: got %b expected 0", bus.cout); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL cin_ovf: got %b expected 0", bus.ovf); end
    step();
  endtask

  task automatic test_ignore_start();
    int lat;
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h4321;
    bus.cin   = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.cin   = 1'b0;
    step();
    bus.start = 1'b0;
    lat = 3;
    while (bus.done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    tests++; if (lat !== 8) begin fails++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    tests++; if (bus.sum !== 16'h5556) begin fails++; $display("FAIL ignore_sum: got %h expected 5556", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL ignore_cout: got %b expected 0", bus.cout); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ignore_ovf: got %b expected 0", bus.ovf); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.start = 1'b1;
    bus.a     = 16'h0003;
    bus.b     = 16'h0004;
    bus.cin   = 1'b0;
    step();
    bus.a = 16'h0100;
    bus.b = 16'h0200;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    tests++; if (lat !== 8) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 8", lat); end
    tests++; if (bus.sum !== 16'h0007) begin fails++; $display("FAIL b2b_first_sum: got %h expected 0007", bus.sum); end
    step();
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_rerun_busy: got %b expected 1", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL b2b_rerun_done: got %b expected 0", bus.done); end
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    tests++; if (lat !== 8) begin fails++; $display("FAIL b2b_second_latency: got %0d expected 8", lat); end
    tests++; if (bus.sum !== 16'h0300) begin fails++; $display("FAIL b2b_second_sum: got %h expected 0300", bus.sum); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt, seen;
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0001;
    bus.cin   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    tests++; if (bus.sum !== 16'h0000) begin fails++; $display("FAIL midrst_sum: got %h expected 0000", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL midrst_cout: got %b expected 0", bus.cout); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL midrst_ovf: got %b expected 0", bus.ovf); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen); end
    do_op(16'h00FF, 16'h0001, 1'b0, lat, bcnt);
    tests++; if (lat !== 8) begin fails++; $display("FAIL postrst_latency: got %0d expected 8", lat); end
    tests++; if (bus.sum !== 16'h0100) begin fails++; $display("FAIL postrst_sum: got %h expected 0100", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL postrst_cout: got %b expected 0", bus.cout); end
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_ripple();
    test_overflow();
    test_cin();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
